adder_bist: RTL and testbench
=============================

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 The interface SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter NUM_VECTORS, default 16, SHALL set the vectors per run (range 1..255).
REQ-003 Parameter SEED, default 9'h1A5, SHALL set the nonzero LFSR seed.
REQ-004 Parameter LAT, default 2, SHALL set the DUT latency in clk cycles, from vector drive to valid c_i.
REQ-005 Ports SHALL be:
  clk  in  1  clock; all state updates on posedge.
  rst_n  in  1  async active-low reset.
  start  in  1  begin run (sampled in IDLE/DONE only).
  a_o  out  4  operand A to DUT.
  b_o  out  4  operand B to DUT.
  cin_o  out  1  carry-in to DUT.
  c_i  in  5  DUT result {carry, sum[3:0]}.
  busy  out  1  run or drain in progress.
  done  out  1  run complete (level, held until restart or reset).
  pass  out  1  done and zero errors.
  err_count  out  8  mismatch count, saturating at 255.
  fail_vec  out  19  first failure {a,b,cin,expected[4:0],got[4:0]}.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DRAIN, DONE, and reset SHALL place it in IDLE.
REQ-007 In IDLE or DONE with start=1, the next edge SHALL enter RUN, reload the LFSR with SEED, clear err_count, pass, done and the fail capture, and set busy.
REQ-008 start SHALL be ignored in RUN and DRAIN.
REQ-009 In RUN, one vector SHALL be issued per cycle, with {a_o,b_o,cin_o} = LFSR[8:0] registered, for exactly NUM_VECTORS consecutive cycles, and the first vector SHALL be valid in the cycle after the start-sampling edge.
REQ-010 The LFSR SHALL be 9-bit Fibonacci, x^9+x^5+1, advancing once per issued vector.
REQ-011 After the last vector, RUN→DRAIN; DRAIN SHALL last LAT cycles, then →DONE.
REQ-012 Outside RUN, a_o, b_o and cin_o SHALL hold their last value.
REQ-013 Expected result SHALL be the 5-bit zero-extended sum a+b+cin computed at issue time, carried in a LAT-deep delay line with a valid bit per stage.
REQ-014 At the end of cycle t+LAT, for a vector issued in cycle t, c_i SHALL be compared to expected only when the valid bit is set; non-issued slots SHALL never compare.
REQ-015 Each mismatch SHALL increment err_count by 1, and the count SHALL hold at 255 with no wrap.
REQ-016 On DONE entry, done SHALL be 1, busy SHALL be 0 and pass SHALL be (err_count==0), including the final compare's contribution.
REQ-017 With start held high continuously, DONE→RUN SHALL occur on the edge after DONE entry; done SHALL be 1 for exactly one cycle.

Reset
REQ-018 rst_n=0 SHALL immediately force: state=IDLE, a_o=0, b_o=0, cin_o=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, delay-line valids=0, LFSR=SEED.
REQ-019 Reset mid-RUN or mid-DRAIN SHALL abort the run with no compare pending after release; the next start SHALL repeat an identical vector sequence.

Configuration
REQ-020 With macro ADDER_BIST_FAILLOG_EN defined, fail_vec SHALL capture the first mismatching vector of a run and hold it until the next start or reset.
REQ-021 Without ADDER_BIST_FAILLOG_EN, fail_vec SHALL be constant 0, no capture registers SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-022 Golden registered 4-bit adder (LAT=2), NUM_VECTORS=16, start pulsed once: busy=1 for 18 cycles, done=1 on the 18th edge after the start-sampling edge, err_count=0, pass=1.
REQ-023 Same setup with DUT c_i[0] stuck at 0: err_count equals the count of odd expected sums across the 16 vectors (bench recomputes from the LFSR), pass=0, and fail_vec equals the first such vector (FAILLOG build).
REQ-024 NUM_VECTORS=1, golden DUT: exactly one vector is driven, done follows after 2 more edges, and pass=1.
REQ-025 Constant mismatch, NUM_VECTORS=255, two back-to-back runs: err_count=255 at the end of each run with no wrap, and it is cleared to 0 at the second start.
REQ-026 Golden DUT, rst_n asserted during the 5th RUN cycle, then start: state=IDLE with all outputs 0 during reset, and the post-reset run's a_o/b_o/cin_o sequence matches the first run from vector 1.
REQ-027 Non-FAILLOG build with a failing DUT: fail_vec=0 throughout, and err_count and pass match the FAILLOG build.

Source files
------------

// File: rtl/adder_bist.sv
// Built-in self test for a 4-bit adder: LFSR vectors out, latency-matched compare in.
// Define ADDER_BIST_FAILLOG_EN to capture the first failing vector on fail_vec.
module adder_bist #(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [8:0]  SEED        = 9'h1A5,
  parameter int unsigned LAT         = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  a_o,
  output logic [3:0]  b_o,
  output logic        cin_o,
  input  logic [4:0]  c_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [18:0] fail_vec
);

  localparam logic [7:0] NV   = 8'(NUM_VECTORS);
  localparam logic [7:0] LATW = 8'(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state;
  logic [8:0] lfsr;
  logic [7:0] vec_cnt;
  logic [7:0] drain_cnt;
  logic       issued;
  logic [4:0] exp_now;
  logic       miss;
  logic [7:0] err_next;

  logic [LAT-1:0] pv;
  logic [4:0]     pe [LAT];

  function automatic logic [8:0] lfsr_next(input logic [8:0] v);
    return {v[7:0], v[8] ^ v[4]};
  endfunction

  always_comb exp_now = {1'b0, a_o} + {1'b0, b_o} + {4'b0, cin_o};

  always_comb begin
    miss     = pv[LAT-1] && (c_i != pe[LAT-1]);
    err_next = err_count;
    if (miss && (err_count != 8'hFF))
      err_next = err_count + 8'd1;
  end

  // Expected sum is taken from the registered operands during their issue
  // cycle, so the line only needs LAT stages to line up with c_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int unsigned i = 0; i < LAT; i++) pe[i] <= '0;
    end else begin
      pv[0] <= issued;
      pe[0] <= exp_now;
      for (int unsigned i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_o       <= '0;
      b_o       <= '0;
      cin_o     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      lfsr      <= SEED;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      issued    <= 1'b0;
    end else begin
      err_count <= err_next;
      issued    <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state               <= RUN;
            {a_o, b_o, cin_o}   <= SEED;
            lfsr                <= lfsr_next(SEED);
            vec_cnt             <= 8'd1;
            issued              <= 1'b1;
            err_count           <= '0;
            pass                <= 1'b0;
            done                <= 1'b0;
            busy                <= 1'b1;
          end
        end
        RUN: begin
          if (vec_cnt == NV) begin
            state     <= DRAIN;
            drain_cnt <= 8'd1;
          end else begin
            {a_o, b_o, cin_o} <= lfsr;
            lfsr              <= lfsr_next(lfsr);
            vec_cnt           <= vec_cnt + 8'd1;
            issued            <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LATW) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_BIST_FAILLOG_EN
  logic [8:0]  pin [LAT];
  logic [18:0] fail_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) pin[i] <= '0;
    end else begin
      pin[0] <= {a_o, b_o, cin_o};
      for (int unsigned i = 1; i < LAT; i++) pin[i] <= pin[i-1];
    end
  end

  // err_count still zero means this mismatch is the first of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fail_reg <= '0;
    else if (((state == IDLE) || (state == DONE)) && start)
      fail_reg <= '0;
    else if (miss && (err_count == '0))
      fail_reg <= {pin[LAT-1], pe[LAT-1], c_i};
  end

  assign fail_vec = fail_reg;
`else
  assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: three instances (16, 1 and 255 vectors)
// each driving a behavioural registered adder with selectable fault modes.
`timescale 1ns/1ps
module tb_adder_bist;

  localparam logic [8:0] SEED = 9'h1A5;
  localparam int         LAT  = 2;

  logic        clk = 1'b0;
  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic [3:0]  a_v [3];
  logic [3:0]  b_v [3];
  logic        cin_v [3];
  logic [4:0]  c_v [3];
  logic [2:0]  busy_v, done_v, pass_v;
  logic [7:0]  err_v [3];
  logic [18:0] fv_v [3];
  int          mode_v [3];
  logic [8:0]  rmask;
  logic [4:0]  s1 [3];
  logic [4:0]  s2 [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_bist #(.NUM_VECTORS(16), .SEED(SEED), .LAT(LAT)) u_main (
    .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .a_o(a_v[0]), .b_o(b_v[0]),
    .cin_o(cin_v[0]), .c_i(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .fail_vec(fv_v[0]));

  adder_bist #(.NUM_VECTORS(1), .SEED(SEED), .LAT(LAT)) u_one (
    .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .a_o(a_v[1]), .b_o(b_v[1]),
    .cin_o(cin_v[1]), .c_i(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .fail_vec(fv_v[1]));

  adder_bist #(.NUM_VECTORS(255), .SEED(SEED), .LAT(LAT)) u_big (
    .clk(clk), .rst_n(rst_v[2]), .start(start_v[2]), .a_o(a_v[2]), .b_o(b_v[2]),
    .cin_o(cin_v[2]), .c_i(c_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .fail_vec(fv_v[2]));

  function automatic logic [4:0] sum_of(input logic [8:0] v);
    int s;
    s = int'(v[8:5]) + int'(v[4:1]) + int'(v[0]);
    return 5'(s);
  endfunction

  // Result the device under test returns: 0 golden, 1 bit0 stuck low,
  // 2 always wrong, 3 bit0 flipped when the vector hits the random mask.
  function automatic logic [4:0] got_of(input int mode, input logic [8:0] v);
    logic [4:0] s;
    s = sum_of(v);
    case (mode)
      1:       return s & 5'h1E;
      2:       return ~s;
      3:       return s ^ {4'b0, ^(v & rmask)};
      default: return s;
    endcase
  endfunction

  // x^9 + x^5 + 1: new bit is the XOR of the x^9 and x^5 terms.
  function automatic logic [8:0] lfsr_step(input logic [8:0] v);
    return {v[7:0], v[8] ^ v[4]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      s1[i] <= got_of(mode_v[i], {a_v[i], b_v[i], cin_v[i]});
      s2[i] <= s1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) c_v[i] = s2[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int u, input string tag);
    check(tag, 32'({a_v[u], b_v[u], cin_v[u], busy_v[u], done_v[u], pass_v[u], err_v[u]}), 32'd0);
    check({tag, "_fv"}, 32'(fv_v[u]), 32'd0);
  endtask

  task automatic do_run(input int u, input int n, input int mode, input bit hold);
    logic [8:0]  vecs [$];
    logic [8:0]  v;
    logic [4:0]  g;
    int          exp_err;
    logic [18:0] exp_fv;
    int          busy_cnt;
    int          done_edge;

    mode_v[u] = mode;
    v = SEED;
    exp_err = 0;
    exp_fv = '0;
    for (int k = 0; k < n; k++) begin
      vecs.push_back(v);
      g = got_of(mode, v);
      if (g != sum_of(v)) begin
        if (exp_err == 0) exp_fv = {v, sum_of(v), g};
        if (exp_err < 255) exp_err++;
      end
      v = lfsr_step(v);
    end
`ifndef ADDER_BIST_FAILLOG_EN
    exp_fv = '0;
`endif

    start_v[u] = 1'b1;
    busy_cnt = 0;
    done_edge = 0;
    for (int cyc = 1; cyc <= n + LAT + 8; cyc++) begin
      @(negedge clk);
      if (!hold) start_v[u] = 1'b0;
      if (cyc == 1) begin
        check("clr_err", 32'(err_v[u]), 32'd0);
        check("clr_done", 32'(done_v[u]), 32'd0);
      end
      if (cyc <= n) check("vec", 32'({a_v[u], b_v[u], cin_v[u]}), 32'(vecs[cyc-1]));
      if (busy_v[u]) busy_cnt++;
      if (done_v[u]) begin
        done_edge = cyc - 1;
        break;
      end
    end
    check("done_edge", 32'(done_edge), 32'(n + LAT));
    check("busy_cycles", 32'(busy_cnt), 32'(n + LAT));
    check("busy_off", 32'(busy_v[u]), 32'd0);
    check("err_count", 32'(err_v[u]), 32'(exp_err));
    check("pass", 32'(pass_v[u]), 32'(exp_err == 0));
    check("fail_vec", 32'(fv_v[u]), 32'(exp_fv));
    check("vec_hold", 32'({a_v[u], b_v[u], cin_v[u]}), 32'(vecs[n-1]));

    @(negedge clk);
    if (hold) begin
      check("done_1cyc", 32'(done_v[u]), 32'd0);
      check("rerun_busy", 32'(busy_v[u]), 32'd1);
      check("rerun_vec", 32'({a_v[u], b_v[u], cin_v[u]}), 32'(SEED));
      start_v[u] = 1'b0;
      done_edge = 0;
      for (int cyc = 2; cyc <= n + LAT + 8; cyc++) begin
        @(negedge clk);
        if (done_v[u]) begin
          done_edge = cyc - 1;
          break;
        end
      end
      check("rerun_done_edge", 32'(done_edge), 32'(n + LAT));
      check("rerun_err", 32'(err_v[u]), 32'(exp_err));
      @(negedge clk);
    end else begin
      check("done_level", 32'(done_v[u]), 32'd1);
      check("pass_level", 32'(pass_v[u]), 32'(exp_err == 0));
    end
  endtask

  task automatic reset_test(input int rst_cyc);
    mode_v[0] = 0;
    start_v[0] = 1'b1;
    for (int cyc = 1; cyc <= rst_cyc; cyc++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    rst_v[0] = 1'b0;
    #1;
    check_zero(0, "rst_mid");
    repeat (2) @(negedge clk);
    check_zero(0, "rst_hold");
    rst_v[0] = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    do_run(0, 16, 0, 1'b0);
  endtask

  initial begin
    rst_v   = '0;
    start_v = '0;
    rmask   = '0;
    for (int i = 0; i < 3; i++) mode_v[i] = 0;
    #2;
    for (int i = 0; i < 3; i++) check_zero(i, "por");
    repeat (2) @(negedge clk);
    rst_v = '1;
    @(negedge clk);

    do_run(0, 16, 0, 1'b0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    do_run(0, 16, 1, 1'b0);
    do_run(1, 1, 0, 1'b0);
    do_run(2, 255, 2, 1'b0);
    do_run(2, 255, 2, 1'b0);
    reset_test(5);
    reset_test($urandom_range(1, 18));
    do_run(0, 16, 1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      rmask = 9'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(0, 16, 3, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
